// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO, with fixed multi-cycle busy latency.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state  | meaning
  // S_IDLE | counter == 0, HI/LO writable by MTHI/MTLO, start accepted
  // S_RUN  | counter > 0, counting down to commit of the latched op

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic            is_mul, is_div, accept;
  logic [63:0]     prod_s, prod_u;
  logic            div_signed, a_neg, b_neg;
  logic [31:0]     a_mag, b_mag, num, den, quo_u, rem_u, quo, rem;
`ifdef MDU_MADD_EN
  logic            is_acc;
`endif

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_acc = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    accept = start && (state_q == S_IDLE) && (is_mul || is_div || is_acc);
`else
    accept = start && (state_q == S_IDLE) && (is_mul || is_div);
`endif
  end

  // Datapath works only from the latched operands so live rs/rt can change freely.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
  end

  // Divide on magnitudes, then fix signs; avoids the signed overflow case of
  // 0x80000000 / -1 and never divides by zero (den forced to 1, result unused).
  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed && a_q[31];
    b_neg      = div_signed && b_q[31];
    a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag      = b_neg ? (~b_q + 32'd1) : b_q;
    num        = a_mag;
    den        = (b_q == 32'd0) ? 32'd1 : b_mag;
    quo_u      = num / den;
    rem_u      = num % den;
    quo        = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
    rem        = a_neg ? (~rem_u + 32'd1) : rem_u;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          a_d     = rs;
          b_d     = rt;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = S_RUN;
        end else if (!start && (op == OP_MTHI)) begin
          hi_d = rs;
        end else if (!start && (op == OP_MTLO)) begin
          lo_d = rs;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out = 32'd0;
    if (op == OP_MFHI)      out = hi_q;
    else if (op == OP_MFLO) out = lo_q;
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares at every commit (busy falling edge).
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] out, hi, lo;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .out(out), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_mc(input logic [3:0] o);
    if (o >= 4'd1 && o <= 4'd4) return 1'b1;
    if (o >= 4'd9 && o <= 4'd12) return MADD_EN;
    return 1'b0;
  endfunction

  // Reference model: ISA-level arithmetic on 64-bit integers.
  task automatic push_expected(input string name, input logic [3:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] acc, pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    pu  = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    case (o)
      4'd1: acc = sa * sb;
      4'd2: acc = pu;
      4'd3: if (b != 32'd0) begin
        q   = sa / sb;
        r   = sa % sb;
        acc = {r[31:0], q[31:0]};
      end
      4'd4: if (b != 32'd0) acc = {a % b, a / b};
      4'd9:  acc = acc + sa * sb;
      4'd10: acc = acc + pu;
      4'd11: acc = acc - sa * sb;
      4'd12: acc = acc - pu;
      default: ;
    endcase
    {m_hi, m_lo} = acc;
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.len  = (o == 4'd3 || o == 4'd4) ? 10 : 5;
    e.name = name;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    logic prev_busy;
    int   len;
    exp_t e;
    prev_busy = 1'b0;
    len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sbq.delete();
        len = 0;
      end else if (busy) begin
        len++;
      end else if (prev_busy) begin
        if (sbq.size() == 0) begin
          check("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
          check({e.name, "_busy_len"}, len, e.len);
        end
        len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic read_check(input string name);
    op = 4'd7; #1;
    check({name, "_mfhi"}, out, m_hi);
    op = 4'd8; #1;
    check({name, "_mflo"}, out, m_lo);
    op = 4'd0; #1;
    check({name, "_out_none"}, out, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (busy && i < 100) begin
      @(negedge clk);
      i++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic do_mc(input string name, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    bit mc;
    mc = is_mc(o);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    if (mc) push_expected(name, o, a, b);
    @(negedge clk);
    start = 1'b0; op = 4'd0; rs = $urandom; rt = $urandom;
    check({name, "_busy_start"}, busy, mc);
    wait_idle(name);
    read_check(name);
  endtask

  task automatic do_mt(input string name, input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o; rs = a;
    @(negedge clk);
    op = 4'd0; rs = $urandom;
    if (o == 4'd5) m_hi = a;
    else m_lo = a;
    read_check(name);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ro;
    int         r;
    reset = 1'b1; start = 1'b0; op = 4'd0; rs = 32'd0; rt = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    read_check("reset");

    do_mc("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    do_mc("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_hi_const", hi, 32'h0000_0002);
    do_mc("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    do_mc("divu_by0", 4'd4, 32'd7, 32'd0);
    do_mc("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'd0);
    do_mt("mthi", 4'd5, 32'h1234_5678);
    check("mthi_const", hi, 32'h1234_5678);
    do_mt("mtlo", 4'd6, 32'h0BAD_F00D);

    // MTLO/MTHI during a divide-by-zero run must leave HI/LO alone.
    @(negedge clk);
    start = 1'b1; op = 4'd4; rs = 32'd7; rt = 32'd0;
    push_expected("mt_in_busy", 4'd4, 32'd7, 32'd0);
    @(negedge clk);
    start = 1'b0; op = 4'd6; rs = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 4'd5; rs = 32'hCAFE_0001;
    @(negedge clk);
    op = 4'd0;
    wait_idle("mt_in_busy");
    read_check("mt_in_busy");

    // Second start during busy: ignored, no length extension.
    @(negedge clk);
    start = 1'b1; op = 4'd1; rs = 32'd1000; rt = 32'hFFFF_FFF0;
    push_expected("restart", 4'd1, 32'd1000, 32'hFFFF_FFF0);
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    start = 1'b1; op = 4'd3; rs = 32'd99; rt = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    wait_idle("restart");
    read_check("restart");

    // MTHI with start asserted: start wins, nothing happens.
    do_mc("mthi_with_start", 4'd5, 32'h5555_AAAA, 32'd0);

    // Reset in the third busy cycle of DIV: dropped, no later commit.
    @(negedge clk);
    start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    check("rst_mid_late_hi", hi, 32'd0);
    check("rst_mid_late_lo", lo, 32'd0);
    read_check("rst_mid");

    do_mt("madd_pre_hi", 4'd5, 32'd0);
    do_mt("madd_pre_lo", 4'd6, 32'hFFFF_FFFF);
    do_mc("maddu", 4'd10, 32'd1, 32'd1);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 19);
      ro = (r > 15) ? 4'(r - 15) : 4'(r);
      if (ro == 4'd5 || ro == 4'd6) do_mt("rnd_mt", ro, rnd32());
      else do_mc("rnd_op", ro, rnd32(), rnd32());
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
